// File: rtl/miner_job_scheduler.sv
// Job scheduler: takes front-end commands, then steps the hash engine through a nonce range.
// Optional engine-timeout watchdog is compiled in when SCHED_WATCHDOG_EN is defined.
module miner_job_scheduler #(
    parameter int NONCE_W = 32
`ifdef SCHED_WATCHDOG_EN
    ,
    parameter logic [15:0] WDOG_CYCLES = 16'd1024
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_ready,
    input  logic [7:0]         in_command,
    input  logic [255:0]       in_buffer,
    output logic               data_request,
    output logic [255:0]       eng_data,
    output logic [NONCE_W-1:0] eng_nonce,
    output logic               eng_start,
    input  logic               eng_done,
    input  logic               eng_found,
    output logic               result_valid,
    output logic [NONCE_W-1:0] result_nonce,
    output logic               result_found,
    input  logic               result_ack,
    output logic               busy,
    output logic               err,
    output logic [NONCE_W-1:0] tried_count,
    output logic [7:0]         debug
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    localparam logic [3:0] CMD_NOP   = 4'd0;
    localparam logic [3:0] CMD_LOAD  = 4'd1;
    localparam logic [3:0] CMD_RANGE = 4'd2;
    localparam logic [3:0] CMD_RUN   = 4'd3;
    localparam logic [3:0] CMD_STOP  = 4'd4;

    state_t               state, state_n;
    logic                 armed, pend;
    logic [7:0]           cmd_q;
    logic [255:0]         buf_q, data_q;
    logic [NONCE_W-1:0]   rng_start, rng_end, nonce, tried, res_nonce;
    logic                 found_q, err_q, res_found;

    logic accept, wdog_timeout;
    logic load_data, load_range, run_start, nonce_inc, tried_inc;
    logic go_report, rep_found, err_set, err_clr, stop, wdog_hit;

    // Handshake: a command is consumed (data_request) in the cycle in_ready, armed and an
    // accepting state coincide; armed re-arms only after in_ready has been seen low.
    assign accept = in_ready && armed && (state == S_IDLE || state == S_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        load_data  = 1'b0;
        load_range = 1'b0;
        run_start  = 1'b0;
        nonce_inc  = 1'b0;
        tried_inc  = 1'b0;
        go_report  = 1'b0;
        rep_found  = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        stop       = 1'b0;
        wdog_hit   = 1'b0;

        // Latched command is decoded one cycle after it was accepted.
        if (pend) begin
            if (cmd_q[7:4] != 4'd0) begin
                err_set = 1'b1;
            end else if (state == S_IDLE) begin
                case (cmd_q[3:0])
                    CMD_NOP:   err_clr = 1'b1;
                    CMD_LOAD:  begin load_data = 1'b1; err_clr = 1'b1; end
                    CMD_RANGE: begin load_range = 1'b1; err_clr = 1'b1; end
                    CMD_RUN: begin
                        if (rng_start > rng_end) err_set = 1'b1;
                        else begin run_start = 1'b1; err_clr = 1'b1; end
                    end
                    default:   err_set = 1'b1;
                endcase
            end else if (cmd_q[3:0] == CMD_STOP) begin
                // A STOP accepted in WAIT may decode in NEXT if eng_done landed on the accept cycle.
                if (state == S_WAIT || state == S_NEXT) begin
                    stop    = 1'b1;
                    err_clr = 1'b1;
                end
            end else begin
                err_set = 1'b1;
            end
        end

        case (state)
            S_IDLE:  if (run_start) state_n = S_ISSUE;
            S_ISSUE: state_n = S_WAIT;
            S_WAIT: begin
                tried_inc = eng_done;
                if (stop)              go_report = 1'b1;
                else if (eng_done)     state_n = S_NEXT;
                else if (wdog_timeout) begin
                    go_report = 1'b1;
                    err_set   = 1'b1;
                    wdog_hit  = 1'b1;
                end
            end
            S_NEXT: begin
                if (stop)                 go_report = 1'b1;
                else if (found_q)         begin go_report = 1'b1; rep_found = 1'b1; end
                else if (nonce == rng_end) go_report = 1'b1;
                else begin
                    nonce_inc = 1'b1;
                    state_n   = S_ISSUE;
                end
            end
            S_REPORT: if (result_ack) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase

        if (go_report) state_n = S_REPORT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            pend      <= 1'b0;
            cmd_q     <= '0;
            buf_q     <= '0;
            data_q    <= '0;
            rng_start <= '0;
            rng_end   <= '0;
            nonce     <= '0;
            tried     <= '0;
            found_q   <= 1'b0;
            err_q     <= 1'b0;
            res_nonce <= '0;
            res_found <= 1'b0;
        end else begin
            if (accept)         armed <= 1'b0;
            else if (!in_ready) armed <= 1'b1;
            pend <= accept;
            if (accept) begin
                cmd_q <= in_command;
                buf_q <= in_buffer;
            end
            if (load_data) data_q <= buf_q;
            if (load_range) begin
                rng_start <= buf_q[2*NONCE_W-1:NONCE_W];
                rng_end   <= buf_q[NONCE_W-1:0];
            end
            if (run_start)      nonce <= rng_start;
            else if (nonce_inc) nonce <= nonce + 1'b1;
            if (run_start)      tried <= '0;
            else if (tried_inc) tried <= tried + 1'b1;
            if (state == S_WAIT && eng_done) found_q <= eng_found;
            if (err_set)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
            if (go_report) begin
                res_nonce <= nonce;
                res_found <= rep_found;
            end
        end
    end

`ifdef SCHED_WATCHDOG_EN
    logic [15:0] wdog_cnt;

    // Zero on the first WAIT cycle, so the limit is reached after WDOG_CYCLES WAIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               wdog_cnt <= '0;
        else if (state != S_WAIT) wdog_cnt <= '0;
        else                      wdog_cnt <= wdog_cnt + 16'd1;
    end

    assign wdog_timeout = (wdog_cnt == WDOG_CYCLES - 16'd1);
`else
    assign wdog_timeout = 1'b0;
`endif

    assign data_request = accept;
    assign eng_data     = data_q;
    assign eng_nonce    = nonce;
    assign eng_start    = (state == S_ISSUE);
    assign result_valid = (state == S_REPORT);
    assign result_nonce = res_nonce;
    assign result_found = res_found;
    assign busy         = (state == S_ISSUE) || (state == S_WAIT) || (state == S_NEXT);
    assign err          = err_q;
    assign tried_count  = tried;
    assign debug        = {wdog_hit, 2'b00, err_q, armed, state};

endmodule

// File: tb/tb_miner_job_scheduler.sv
// Bench for miner_job_scheduler: directed and randomized jobs against a range/hit reference model.
module tb_miner_job_scheduler;

    localparam int NW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_ready;
    logic [7:0]    in_command;
    logic [255:0]  in_buffer;
    logic          data_request;
    logic [255:0]  eng_data;
    logic [NW-1:0] eng_nonce;
    logic          eng_start;
    logic          eng_done;
    logic          eng_found;
    logic          result_valid;
    logic [NW-1:0] result_nonce;
    logic          result_found;
    logic          result_ack;
    logic          busy;
    logic          err;
    logic [NW-1:0] tried_count;
    logic [7:0]    debug;

    logic auto_done, auto_found, man_done, man_found;
    bit   eng_auto;
    bit   hit_en;
    logic [NW-1:0] hit_nonce;

    assign eng_done  = eng_auto ? auto_done  : man_done;
    assign eng_found = eng_auto ? auto_found : man_found;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_count = 0;
    int dr_count = 0;
    int wdog_seen = 0;
    bit done_pend = 1'b0;
    int done_cyc = 0;
    logic [NW-1:0] obs_q[$];
    logic [NW-1:0] exp_q[$];

`ifdef SCHED_WATCHDOG_EN
    miner_job_scheduler #(.NONCE_W(NW), .WDOG_CYCLES(16'd8)) dut (
`else
    miner_job_scheduler #(.NONCE_W(NW)) dut (
`endif
        .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .in_command(in_command),
        .in_buffer(in_buffer), .data_request(data_request), .eng_data(eng_data),
        .eng_nonce(eng_nonce), .eng_start(eng_start), .eng_done(eng_done),
        .eng_found(eng_found), .result_valid(result_valid), .result_nonce(result_nonce),
        .result_found(result_found), .result_ack(result_ack), .busy(busy), .err(err),
        .tried_count(tried_count), .debug(debug)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL global_timeout observed=%0d cycles expected=finish", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- engine model and observers ----------------
    initial begin : engine
        logic [NW-1:0] n;
        int d;
        auto_done  = 1'b0;
        auto_found = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_auto && eng_start) begin
                n = eng_nonce;
                d = $urandom_range(1, 4);
                repeat (d) @(posedge clk);
                #1;
                auto_done  = 1'b1;
                auto_found = hit_en && (n == hit_nonce);
                @(posedge clk);
                #1;
                auto_done  = 1'b0;
                auto_found = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (data_request) dr_count++;
        if (debug[7]) wdog_seen++;
        if (eng_start) begin
            start_count++;
            obs_q.push_back(eng_nonce);
            if (done_pend) begin
                check("done_to_start_latency", 256'(cyc - done_cyc), 256'(2));
                done_pend = 1'b0;
            end
        end
        if (eng_auto && eng_done && busy) begin
            done_pend = 1'b1;
            done_cyc  = cyc;
        end
        if (result_valid) done_pend = 1'b0;
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [7:0] c, input logic [255:0] p);
        bit got = 1'b0;
        in_command = c;
        in_buffer  = p;
        in_ready   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (data_request) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("cmd_accept_%0h", c), 256'(got), 256'(1));
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        tick();
    endtask

    task automatic wait_state(input logic [2:0] st, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (debug[2:0] == st) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 256'(hit), 256'(1));
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check("ack_valid_drop", 256'(result_valid), 256'(0));
        check("ack_idle", 256'(debug[2:0]), 256'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_request"}, 256'(data_request), 256'(0));
        check({tag, "_eng_start"},    256'(eng_start), 256'(0));
        check({tag, "_eng_data"},     eng_data, 256'(0));
        check({tag, "_eng_nonce"},    256'(eng_nonce), 256'(0));
        check({tag, "_result_valid"}, 256'(result_valid), 256'(0));
        check({tag, "_result"},       256'({result_nonce, result_found}), 256'(0));
        check({tag, "_busy_err"},     256'({busy, err}), 256'(0));
        check({tag, "_tried"},        256'(tried_count), 256'(0));
        check({tag, "_debug"},        256'(debug), 256'(0));
    endtask

    // Reference: attempts run start, start+1, ... and stop at the hit or at the inclusive end.
    task automatic run_job(input logic [NW-1:0] s, input logic [NW-1:0] e,
                           input bit hen, input logic [NW-1:0] hn);
        logic [NW:0]   n;
        bit            exp_found;
        bit            got;
        int            lim;
        exp_q.delete();
        n = {1'b0, s};
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(n[NW-1:0]);
            if ((hen && n[NW-1:0] == hn) || n[NW-1:0] == e) break;
            n = n + 1;
        end
        exp_found = hen && (hn >= s) && (hn <= e);
        hit_en    = hen;
        hit_nonce = hn;
        eng_auto  = 1'b1;
        obs_q.delete();
        send_cmd(8'h02, {192'd0, s, e});
        send_cmd(8'h03, 256'd0);
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (result_valid) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("job_%0h_result_valid", s), 256'(got), 256'(1));
        check($sformatf("job_%0h_found", s), 256'(result_found), 256'(exp_found));
        check($sformatf("job_%0h_nonce", s), 256'(result_nonce), 256'(exp_q[$]));
        check($sformatf("job_%0h_tried", s), 256'(tried_count), 256'(exp_q.size()));
        check($sformatf("job_%0h_busy", s), 256'(busy), 256'(0));
        check($sformatf("job_%0h_attempts", s), 256'(obs_q.size()), 256'(exp_q.size()));
        lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int k = 0; k < lim; k++)
            check($sformatf("job_%0h_nonce_seq%0d", s, k), 256'(obs_q[k]), 256'(exp_q[k]));
        do_ack();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : stim
        logic [NW-1:0] s, e, hn;
        logic [255:0]  pl;
        int            len, sc, d0, c0;
        bit            got;

        rst_n      = 1'b0;
        in_ready   = 1'b0;
        in_command = '0;
        in_buffer  = '0;
        result_ack = 1'b0;
        man_done   = 1'b0;
        man_found  = 1'b0;
        eng_auto   = 1'b1;
        hit_en     = 1'b0;
        hit_nonce  = '0;
        #12;
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // LOAD then the two ranged jobs from the plan
        pl = {32{8'hA5}};
        send_cmd(8'h01, pl);
        check("load_data", eng_data, pl);
        run_job(32'h10, 32'h13, 1'b0, 32'h0);
        run_job(32'h10, 32'h13, 1'b1, 32'h12);

        // start > end is rejected
        sc = start_count;
        send_cmd(8'h02, {192'd0, 32'h20, 32'h1F});
        send_cmd(8'h03, 256'd0);
        repeat (4) tick();
        check("badrange_err", 256'({err, debug[4]}), 256'(2'b11));
        check("badrange_idle", 256'({busy, debug[2:0]}), 256'(0));
        check("badrange_no_start", 256'(start_count - sc), 256'(0));
        send_cmd(8'h00, 256'd0);
        check("nop_clears_err", 256'(err), 256'(0));

        // illegal codes, upper nibble set, STOP outside WAIT
        send_cmd(8'h09, 256'd0);
        check("bad_code_err", 256'(err), 256'(1));
        pl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send_cmd(8'h01, pl);
        check("load_clears_err", 256'(err), 256'(0));
        check("load_random_data", eng_data, pl);
        send_cmd(8'h11, 256'd0);
        check("upper_nibble_err", 256'(err), 256'(1));
        send_cmd(8'h04, 256'd0);
        check("stop_in_idle_err", 256'(err), 256'(1));
        check("stop_in_idle_state", 256'(debug[2:0]), 256'(0));
        send_cmd(8'h00, 256'd0);

        // held in_ready is consumed once; a one-cycle drop re-arms
        d0 = dr_count;
        in_command = 8'h01;
        in_buffer  = pl;
        in_ready   = 1'b1;
        repeat (50) tick();
        check("held_ready_one_pulse", 256'(dr_count - d0), 256'(1));
        in_ready = 1'b0;
        tick();
        in_ready = 1'b1;
        repeat (10) tick();
        check("rearm_second_pulse", 256'(dr_count - d0), 256'(2));
        in_ready = 1'b0;
        tick();
        tick();

        // STOP accepted on the same cycle as a found eng_done
        eng_auto = 1'b0;
        send_cmd(8'h02, {192'd0, 32'h100, 32'h1FF});
        sc = start_count;
        send_cmd(8'h03, 256'd0);
        wait_state(3'd2, "stop_reach_wait");
        in_command = 8'h04;
        in_ready   = 1'b1;
        man_done   = 1'b1;
        man_found  = 1'b1;
        @(negedge clk);
        check("stop_same_cycle_accept", 256'(data_request), 256'(1));
        @(posedge clk);
        #1;
        in_ready  = 1'b0;
        man_done  = 1'b0;
        man_found = 1'b0;
        tick();
        check("stop_report_valid", 256'(result_valid), 256'(1));
        check("stop_found", 256'(result_found), 256'(0));
        check("stop_nonce", 256'(result_nonce), 256'(32'h100));
        check("stop_tried", 256'(tried_count), 256'(1));
        repeat (3) tick();
        check("stop_no_more_start", 256'(start_count - sc), 256'(1));
        do_ack();

        // plain STOP in WAIT with no engine completion
        send_cmd(8'h03, 256'd0);
        wait_state(3'd2, "stop2_reach_wait");
        send_cmd(8'h04, 256'd0);
        check("stop2_valid", 256'(result_valid), 256'(1));
        check("stop2_result", 256'({result_found, result_nonce}), 256'({1'b0, 32'h100}));
        check("stop2_tried", 256'(tried_count), 256'(0));
        check("stop2_err", 256'(err), 256'(0));
        do_ack();

        // asynchronous reset mid-job
        send_cmd(8'h02, {192'd0, 32'h55, 32'h60});
        send_cmd(8'h03, 256'd0);
        wait_state(3'd2, "rst_reach_wait");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midjob_reset");
        sc = start_count;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("post_reset_no_start", 256'(start_count - sc), 256'(0));
        check("post_reset_idle", 256'({busy, debug[2:0]}), 256'(0));
        eng_auto = 1'b1;

        // boundary ranges: all-ones end, single-nonce range, hit on start
        run_job(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32'h0);
        run_job(32'h40, 32'h40, 1'b0, 32'h0);
        run_job(32'h77, 32'h7A, 1'b1, 32'h77);

        // randomized jobs
        for (int j = 0; j < 8; j++) begin
            pl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send_cmd(8'h01, pl);
            check($sformatf("rand%0d_data", j), eng_data, pl);
            s = $urandom;
            if (s > 32'hFFFF_FF00) s = s - 32'h100;
            len = $urandom_range(1, 6);
            e   = s + NW'(len - 1);
            hn  = s + NW'($urandom_range(0, len));
            run_job(s, e, 1'($urandom_range(0, 1)), hn);
        end

`ifdef SCHED_WATCHDOG_EN
        eng_auto = 1'b0;
        send_cmd(8'h02, {192'd0, 32'h7, 32'h9});
        d0 = wdog_seen;
        send_cmd(8'h03, 256'd0);
        c0  = -1;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (eng_start) c0 = cyc;
            if (result_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("wdog_report", 256'(got), 256'(1));
        check("wdog_latency", 256'(cyc - c0), 256'(9));
        check("wdog_err", 256'(err), 256'(1));
        check("wdog_found", 256'(result_found), 256'(0));
        check("wdog_debug_pulse", 256'(wdog_seen - d0), 256'(1));
        do_ack();
        eng_auto = 1'b1;
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
